// File: rtl/bldc_pkg.sv
// bldc_pkg: shared FSM state type, default constants and the
// signed clamp helper used by the BLDC speed controller.
package bldc_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_K_WIDTH    = 8;
    localparam int DEF_FRAC_BITS  = 4;
    localparam int DEF_PWM_PERIOD = 255;
    localparam int DEF_DEADTIME   = 4;
    localparam int DEF_INT_LIMIT  = 1023;
    localparam int DEF_LOCK_TOL   = 8;

    // in-tolerance updates needed before locked asserts
    localparam int LOCK_COUNT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // clamp v into [lo, hi]; callers size-cast the result
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/bldc_enc_period.sv
// bldc_enc_period: encoder synchroniser, double-edge error flag and
// period counter. Ports: clk/reset, encoder_a/b in; period_measured,
// stalled, enc_error out.
module bldc_enc_period
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 2**DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  encoder_a,
    input  logic                  encoder_b,
    output logic [DATA_WIDTH-1:0] period_measured,
    output logic                  stalled,
    output logic                  enc_error
);

    localparam logic [DATA_WIDTH-1:0] TMO = DATA_WIDTH'(TIMEOUT);

    logic                  a_meta_q, a_sync_q, a_prev_q;
    logic                  b_meta_q, b_sync_q, b_prev_q;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] per_q, per_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;
    logic                  a_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            a_prev_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
            b_prev_q <= 1'b0;
            cnt_q    <= '0;
            per_q    <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_meta_q <= encoder_a;
            a_sync_q <= a_meta_q;
            a_prev_q <= a_sync_q;
            b_meta_q <= encoder_b;
            b_sync_q <= b_meta_q;
            b_prev_q <= b_sync_q;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        a_rise  = a_sync_q & ~a_prev_q;
        // both phases moving at once is not a legal quadrature step
        err_d   = (a_sync_q ^ a_prev_q) & (b_sync_q ^ b_prev_q);
        cnt_d   = cnt_q;
        per_d   = per_q;
        stall_d = stall_q;
        if (a_rise) begin
            per_d   = cnt_q;
            cnt_d   = DATA_WIDTH'(1);
            stall_d = 1'b0;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
            if (cnt_d == TMO) begin
                per_d   = TMO;
                stall_d = 1'b1;
            end
        end
    end

    assign period_measured = per_q;
    assign stalled         = stall_q;
    assign enc_error       = err_q;

endmodule

// File: rtl/bldc_speed_ctrl.sv
// bldc_speed_ctrl: period-based PID speed loop driving a PWM H-bridge
// pair with deadtime. Ports: clk/reset, encoder_a/b, enable, dir_cmd,
// period_reference, kp/ki/kd in; motor_positive/negative,
// period_measured, duty, locked, stalled, enc_error out.
module bldc_speed_ctrl
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K_WIDTH    = DEF_K_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int DEADTIME   = DEF_DEADTIME,
    parameter int INT_LIMIT  = DEF_INT_LIMIT,
    parameter int LOCK_TOL   = DEF_LOCK_TOL,
    parameter int TIMEOUT    = 2**DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  encoder_a,
    input  logic                  encoder_b,
    input  logic                  enable,
    input  logic                  dir_cmd,
    input  logic [DATA_WIDTH-1:0] period_reference,
    input  logic [K_WIDTH-1:0]    kp,
    input  logic [K_WIDTH-1:0]    ki,
    input  logic [K_WIDTH-1:0]    kd,
    output logic                  motor_positive,
    output logic                  motor_negative,
    output logic [DATA_WIDTH-1:0] period_measured,
    output logic [DATA_WIDTH-1:0] duty,
    output logic                  locked,
    output logic                  stalled,
    output logic                  enc_error
);

    localparam int EW  = DATA_WIDTH + 1;
    localparam int IW  = $clog2(INT_LIMIT + 1) + 1;
    // wide enough that no PID term or their sum can overflow
    localparam int SW  = K_WIDTH + EW + IW + 4;
    localparam int DCW = $clog2(DEADTIME + 1) + 1;

    localparam logic [DATA_WIDTH-1:0] PWM_LAST  = DATA_WIDTH'(PWM_PERIOD - 1);
    localparam logic [DCW-1:0]        DEAD_LAST = DCW'(DEADTIME - 1);

    state_e                  state_q, state_d;
    logic [DCW-1:0]          dead_cnt_q, dead_cnt_d;
    logic                    dir_q, dir_d;
    logic [DATA_WIDTH-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic signed [EW-1:0]    err_q, err_d;
    logic signed [EW-1:0]    prev_err_q, prev_err_d;
    logic signed [IW-1:0]    integral_q, integral_d;
    logic [K_WIDTH-1:0]      kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic                    upd_q, upd_d;
    logic [DATA_WIDTH-1:0]   duty_q, duty_d;
    logic                    sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
    logic [3:0]              lock_cnt_q, lock_cnt_d;

    logic                    strobe;
    logic                    pwm;
    logic                    hold;
    logic                    in_tol;
    logic signed [EW-1:0]    err_now;
    logic [EW-1:0]           err_mag;
    logic signed [SW-1:0]    p_term, i_term, d_term;
    logic signed [SW-1:0]    pid_sum, pid_shift;

    bldc_enc_period #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_enc (
        .clk             (clk),
        .reset           (reset),
        .encoder_a       (encoder_a),
        .encoder_b       (encoder_b),
        .period_measured (period_measured),
        .stalled         (stalled),
        .enc_error       (enc_error)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dead_cnt_q <= '0;
            dir_q      <= 1'b0;
            pwm_cnt_q  <= '0;
            err_q      <= '0;
            prev_err_q <= '0;
            integral_q <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            upd_q      <= 1'b0;
            duty_q     <= '0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            dir_q      <= dir_d;
            pwm_cnt_q  <= pwm_cnt_d;
            err_q      <= err_d;
            prev_err_q <= prev_err_d;
            integral_q <= integral_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            upd_q      <= upd_d;
            duty_q     <= duty_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // FSM next state and bridge outputs
    always_comb begin
        state_d        = state_q;
        dead_cnt_d     = dead_cnt_q;
        dir_d          = dir_q;
        motor_positive = 1'b0;
        motor_negative = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end
            end
            ST_DEAD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (dead_cnt_q == DEAD_LAST) begin
                    state_d = ST_RUN;
                    dir_d   = dir_cmd;
                end else begin
                    dead_cnt_d = dead_cnt_q + DCW'(1);
                end
            end
            ST_RUN: begin
                motor_positive = pwm & dir_q;
                motor_negative = pwm & ~dir_q;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (dir_cmd != dir_q) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PID datapath
    always_comb begin
        strobe  = (pwm_cnt_q == PWM_LAST);
        pwm     = (pwm_cnt_q < duty_q);
        err_now = $signed({1'b0, period_measured})
                - $signed({1'b0, period_reference});
        err_mag = err_now[EW-1] ? EW'(-err_now) : EW'(err_now);
        in_tol  = (err_mag <= EW'(LOCK_TOL));
        // freeze the integrator while the output is pinned the same way
        hold    = (sat_hi_q & ~err_now[EW-1] & (|err_now))
                | (sat_lo_q & err_now[EW-1]);

        p_term    = SW'($signed({1'b0, kp_q})) * SW'(err_q);
        i_term    = SW'($signed({1'b0, ki_q})) * SW'(integral_q);
        d_term    = SW'($signed({1'b0, kd_q}))
                  * (SW'(err_q) - SW'(prev_err_q));
        pid_sum   = p_term + i_term + d_term;
        pid_shift = pid_sum >>> FRAC_BITS;

        pwm_cnt_d  = strobe ? '0 : pwm_cnt_q + DATA_WIDTH'(1);
        err_d      = err_q;
        prev_err_d = prev_err_q;
        integral_d = integral_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        upd_d      = 1'b0;
        duty_d     = duty_q;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;
        lock_cnt_d = lock_cnt_q;

        if (strobe) begin
            kp_d = kp;
            ki_d = ki;
            kd_d = kd;
        end

        if (state_q == ST_IDLE) begin
            err_d      = '0;
            prev_err_d = '0;
            integral_d = '0;
            duty_d     = '0;
            sat_hi_d   = 1'b0;
            sat_lo_d   = 1'b0;
            lock_cnt_d = '0;
        end else begin
            if (strobe) begin
                err_d      = err_now;
                prev_err_d = err_q;
                upd_d      = 1'b1;
                if (!hold) begin
                    integral_d = IW'(saturate(
                        64'(integral_q) + 64'(err_now),
                        -64'(INT_LIMIT), 64'(INT_LIMIT)));
                end
                if (in_tol) begin
                    if (lock_cnt_q != 4'(LOCK_COUNT)) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end
            if (upd_q) begin
                duty_d   = DATA_WIDTH'(saturate(64'(pid_shift),
                               64'sd0, 64'(PWM_PERIOD)));
                sat_hi_d = (pid_shift > SW'(PWM_PERIOD));
                sat_lo_d = pid_shift[SW-1];
            end
            if (state_q != ST_RUN || stalled) begin
                lock_cnt_d = '0;
            end
        end
    end

    assign duty   = duty_q;
    assign locked = (lock_cnt_q == 4'(LOCK_COUNT))
                  & (state_q == ST_RUN) & ~stalled;

endmodule

// File: tb/tb_bldc_speed_ctrl.sv
// tb_bldc_speed_ctrl: directed vectors for the BLDC speed controller,
// plus an 8-bit instance for the stall timeout.
module tb_bldc_speed_ctrl;
    import bldc_pkg::*;

    localparam int ENC_PER = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        dir_cmd = 1'b1;
    logic [15:0] period_reference = '0;
    logic [7:0]  kp = '0, ki = '0, kd = '0;
    logic        encoder_a, encoder_b;
    logic        motor_positive, motor_negative;
    logic [15:0] period_measured, duty;
    logic        locked, stalled, enc_error;

    logic        a8 = 1'b0, b8 = 1'b0, en8 = 1'b0;
    logic [7:0]  ref8 = '0;
    logic        mp8, mn8, lk8, st8, ee8;
    logic [7:0]  per8, duty8;

    logic        enc_run = 1'b1;
    logic        man_a = 1'b0, man_b = 1'b0;
    logic        gen_a = 1'b0, gen_b = 1'b0;
    int          gen_cnt = 0;
    int          both_cnt = 0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        gen_cnt <= (gen_cnt == ENC_PER - 1) ? 0 : gen_cnt + 1;
        gen_a   <= (gen_cnt < ENC_PER / 2);
        gen_b   <= (gen_cnt >= ENC_PER / 4) && (gen_cnt < 3 * ENC_PER / 4);
    end

    always @(negedge clk) begin
        if (motor_positive && motor_negative) both_cnt <= both_cnt + 1;
    end

    assign encoder_a = enc_run ? gen_a : man_a;
    assign encoder_b = enc_run ? gen_b : man_b;

    bldc_speed_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .encoder_a        (encoder_a),
        .encoder_b        (encoder_b),
        .enable           (enable),
        .dir_cmd          (dir_cmd),
        .period_reference (period_reference),
        .kp               (kp),
        .ki               (ki),
        .kd               (kd),
        .motor_positive   (motor_positive),
        .motor_negative   (motor_negative),
        .period_measured  (period_measured),
        .duty             (duty),
        .locked           (locked),
        .stalled          (stalled),
        .enc_error        (enc_error)
    );

    bldc_speed_ctrl #(.DATA_WIDTH(8)) dut8 (
        .clk              (clk),
        .reset            (reset),
        .encoder_a        (a8),
        .encoder_b        (b8),
        .enable           (en8),
        .dir_cmd          (1'b1),
        .period_reference (ref8),
        .kp               (kp),
        .ki               (ki),
        .kd               (kd),
        .motor_positive   (mp8),
        .motor_negative   (mn8),
        .period_measured  (per8),
        .duty             (duty8),
        .locked           (lk8),
        .stalled          (st8),
        .enc_error        (ee8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int zeros;
        int errs;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_mpos", 64'(motor_positive), 64'd0);
        chk("rst_mneg", 64'(motor_negative), 64'd0);
        chk("rst_duty", 64'(duty), 64'd0);
        chk("rst_period", 64'(period_measured), 64'd0);
        chk("rst_flags", 64'({locked, stalled, enc_error}), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        reset = 1'b0;

        // 8-bit instance, encoder static: stall exactly at count 255
        repeat (254) @(posedge clk);
        #1 chk("stall_early", 64'(st8), 64'd0);
        @(posedge clk);
        #1 chk("stall_set", 64'(st8), 64'd1);
        chk("stall_period", 64'(per8), 64'd255);
        @(negedge clk) a8 = 1'b1;
        for (int i = 0; i < 8 && st8; i++) @(negedge clk);
        chk("stall_clear", 64'(st8), 64'd0);
        chk("stall_clear_per", 64'(per8), 64'd255);

        for (int i = 0; i < 2500 && period_measured != 16'd1000; i++)
            @(negedge clk);
        chk("period_1000", 64'(period_measured), 64'd1000);

        // on-target speed: zero error, lock after 8 updates
        period_reference = 16'd1000;
        kp = 8'd16; ki = 8'd0; kd = 8'd0;
        dir_cmd = 1'b1; enable = 1'b1;
        repeat (6 * 255) @(negedge clk);
        chk("lock_early", 64'(locked), 64'd0);
        chk("duty_zero", 64'(duty), 64'd0);
        chk("mpos_low", 64'(motor_positive), 64'd0);
        for (int i = 0; i < 4 * 255 && !locked; i++) @(negedge clk);
        chk("lock_set", 64'(locked), 64'd1);
        chk("no_stall", 64'(stalled), 64'd0);

        // too slow: output saturates, integrator frozen
        period_reference = 16'd500;
        repeat (3 * 255) @(negedge clk);
        chk("sat_shift", 64'(dut.pid_shift), 64'd500);
        chk("sat_duty", 64'(duty), 64'd255);
        chk("lock_lost", 64'(locked), 64'd0);
        chk("pwm_full", 64'(motor_positive), 64'd1);
        ki = 8'd1;
        repeat (3 * 255) @(negedge clk);
        chk("int_frozen", 64'(dut.integral_q), 64'd500);
        chk("sat_shift_ki", 64'(dut.pid_shift), 64'd531);
        chk("sat_duty_ki", 64'(duty), 64'd255);

        // direction reversal with deadtime
        dir_cmd = 1'b0;
        zeros = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (motor_positive || motor_negative) seen = 1'b1;
            else zeros++;
        end
        chk("dead_clocks", 64'(zeros), 64'd4);
        chk("rev_on", 64'(motor_negative), 64'd1);
        chk("fwd_off", 64'(motor_positive), 64'd0);

        // simultaneous A/B flip while A is high
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            if (gen_a && gen_b) seen = 1'b1;
        end
        man_a = 1'b1; man_b = 1'b1; enc_run = 1'b0;
        chk("flip_setup", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        chk("no_enc_err", 64'(enc_error), 64'd0);
        man_a = 1'b0; man_b = 1'b0;
        errs = 0;
        repeat (8) begin
            @(negedge clk);
            if (enc_error) errs++;
        end
        chk("enc_err_pulse", 64'(errs), 64'd1);
        chk("flip_period", 64'(period_measured), 64'd1000);

        // duty 128 then reset mid-pulse
        period_reference = 16'd872;
        ki = 8'd0; kd = 8'd0; dir_cmd = 1'b1;
        repeat (3 * 255) @(negedge clk);
        chk("duty_128", 64'(duty), 64'd128);
        for (int i = 0; i < 300 && !motor_positive; i++) @(negedge clk);
        chk("pulse_seen", 64'(motor_positive), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_cut_pos", 64'(motor_positive), 64'd0);
        chk("rst_cut_neg", 64'(motor_negative), 64'd0);
        chk("rst_cut_duty", 64'(duty), 64'd0);
        enable = 1'b0;
        @(negedge clk) reset = 1'b0;
        #1 chk("post_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("post_rst_lock", 64'(locked), 64'd0);

        chk("never_both", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
